// File: rtl/scoreboard_regfile.sv
// Register file with write-back bypass and per-register in-flight write scoreboard.
// Optional macro RF_WR_BYPASS_EN enables same-cycle write-back forwarding and stall credit.
module scoreboard_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD-1:0]        rd_valid_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic                     iss_rdy_o,
    output logic                     stall_o,
    output logic                     err_o
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
    logic              err_q;
    logic              err_d;
    logic              wr_hit;
    logic              iss_dec;
    logic [NUM_RD-1:0] hazard;
    logic [ADDR_W-1:0] rd_addr [NUM_RD];

    assign wr_hit = wr_en_i && (wr_addr_i != '0);

    // A saturated destination can still accept an issue when a write-back retires one slot.
    assign iss_dec   = wr_en_i && (wr_addr_i == iss_addr_i) && (cnt_q[iss_addr_i] != '0);
    assign iss_rdy_o = (iss_addr_i == '0) || (cnt_q[iss_addr_i] != CNT_MAX) || iss_dec;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            logic inc;
            logic dec;
            inc = iss_en_i && iss_rdy_o && (iss_addr_i == ADDR_W'(r));
            dec = wr_en_i && (wr_addr_i == ADDR_W'(r)) && (cnt_q[r] != '0);
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    assign err_d = err_q || (wr_hit && (cnt_q[wr_addr_i] == '0));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (wr_hit) begin
                regs_q[wr_addr_i] <= wr_data_i;
            end
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    // Per read port: data select and hazard detection.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign rd_addr[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
`ifdef RF_WR_BYPASS_EN
        logic wr_match;
        assign wr_match = wr_en_i && (wr_addr_i == rd_addr[k]);
        assign rd_data_o[k*DATA_W +: DATA_W] = (rd_addr[k] == '0) ? '0 :
                                               wr_match           ? wr_data_i :
                                                                    regs_q[rd_addr[k]];
        // The write landing this cycle satisfies one pending count.
        assign hazard[k] = rd_valid_i[k] && (rd_addr[k] != '0) &&
                           (cnt_q[rd_addr[k]] > CNT_W'(wr_match));
`else
        assign rd_data_o[k*DATA_W +: DATA_W] = (rd_addr[k] == '0) ? '0 : regs_q[rd_addr[k]];
        assign hazard[k] = rd_valid_i[k] && (rd_addr[k] != '0) &&
                           (cnt_q[rd_addr[k]] != '0);
`endif
    end

    assign stall_o = |hazard;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed self-checking bench for scoreboard_regfile (default parameters).
module tb_scoreboard_regfile;

    logic        clk_i;
    logic        rst_i;
    logic [1:0]  rd_valid_i;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        iss_en_i;
    logic [4:0]  iss_addr_i;
    logic        iss_rdy_o;
    logic        stall_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    scoreboard_regfile dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_valid_i (rd_valid_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .iss_rdy_o  (iss_rdy_o),
        .stall_o    (stall_o),
        .err_o      (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i      = 1'b0;
        rd_valid_i = '0;
        rd_addr_i  = '0;
        wr_en_i    = 1'b0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        iss_en_i   = 1'b0;
        iss_addr_i = '0;

        // Reset then read
        tick();
        tick();
        chk("rst_err", 64'(err_o), 64'(0));
        rst_i      = 1'b1;
        rd_addr_i  = {5'd3, 5'd0};
        rd_valid_i = 2'b11;
        #1;
        chk("rst_rd_data", rd_data_o, 64'h0);
        chk("rst_stall", 64'(stall_o), 64'(0));
        chk("rst_iss_rdy", 64'(iss_rdy_o), 64'(1));

        // Load-use on r8
        rd_valid_i = 2'b00;
        iss_en_i   = 1'b1;
        iss_addr_i = 5'd8;
        #1;
        chk("lu_iss_rdy", 64'(iss_rdy_o), 64'(1));
        tick();
        iss_en_i   = 1'b0;
        rd_addr_i  = {5'd0, 5'd8};
        rd_valid_i = 2'b01;
        #1;
        chk("lu_stall_c1", 64'(stall_o), 64'(1));
        tick();
        chk("lu_stall_c2", 64'(stall_o), 64'(1));
        tick();
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd8;
        wr_data_i = 32'hDEADBEEF;
        #1;
`ifdef RF_WR_BYPASS_EN
        chk("lu_c3_data", 64'(rd_data_o[31:0]), 64'hDEADBEEF);
        chk("lu_c3_stall", 64'(stall_o), 64'(0));
`else
        chk("lu_c3_data", 64'(rd_data_o[31:0]), 64'h0);
        chk("lu_c3_stall", 64'(stall_o), 64'(1));
`endif
        tick();
        wr_en_i = 1'b0;
        #1;
        chk("lu_c4_data", 64'(rd_data_o[31:0]), 64'hDEADBEEF);
        chk("lu_c4_stall", 64'(stall_o), 64'(0));
        chk("lu_err", 64'(err_o), 64'(0));

        // Counter saturation on r5
        rd_valid_i = 2'b00;
        iss_addr_i = 5'd5;
        for (int i = 0; i < 3; i++) begin
            iss_en_i = 1'b1;
            #1;
            chk("sat_iss_rdy", 64'(iss_rdy_o), 64'(1));
            tick();
        end
        #1;
        chk("sat_full_rdy", 64'(iss_rdy_o), 64'(0));
        tick();
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd5;
        wr_data_i = 32'h50;
        #1;
        chk("sat_wr_rdy", 64'(iss_rdy_o), 64'(1));
        tick();
        iss_en_i = 1'b0;
        wr_en_i  = 1'b0;
        #1;
        chk("sat_still_full", 64'(iss_rdy_o), 64'(0));
        rd_addr_i  = {5'd0, 5'd5};
        rd_valid_i = 2'b01;
        for (int i = 0; i < 3; i++) begin
            wr_en_i   = 1'b1;
            wr_data_i = 32'h51 + 32'(i);
            tick();
            wr_en_i = 1'b0;
            #1;
            chk("sat_drain_stall", 64'(stall_o), (i == 2) ? 64'(0) : 64'(1));
        end
        chk("sat_drain_data", 64'(rd_data_o[31:0]), 64'h53);
        chk("sat_drain_rdy", 64'(iss_rdy_o), 64'(1));
        chk("sat_err", 64'(err_o), 64'(0));

        // Zero register
        iss_en_i   = 1'b1;
        iss_addr_i = 5'd0;
        rd_valid_i = 2'b00;
        #1;
        chk("r0_iss_rdy", 64'(iss_rdy_o), 64'(1));
        tick();
        iss_en_i   = 1'b0;
        wr_en_i    = 1'b1;
        wr_addr_i  = 5'd0;
        wr_data_i  = 32'h1234;
        rd_addr_i  = {5'd0, 5'd0};
        rd_valid_i = 2'b11;
        #1;
        chk("r0_rd_bypass", rd_data_o, 64'h0);
        chk("r0_stall", 64'(stall_o), 64'(0));
        tick();
        wr_en_i = 1'b0;
        #1;
        chk("r0_rd", rd_data_o, 64'h0);
        chk("r0_err", 64'(err_o), 64'(0));

        // Spurious write-back to r9
        wr_en_i    = 1'b1;
        wr_addr_i  = 5'd9;
        wr_data_i  = 32'h7;
        rd_addr_i  = {5'd0, 5'd9};
        rd_valid_i = 2'b01;
        #1;
        chk("sp_err_before", 64'(err_o), 64'(0));
        tick();
        wr_en_i = 1'b0;
        #1;
        chk("sp_err", 64'(err_o), 64'(1));
        chk("sp_rd", 64'(rd_data_o[31:0]), 64'h7);
        chk("sp_stall", 64'(stall_o), 64'(0));
        tick();
        tick();
        chk("sp_err_sticky", 64'(err_o), 64'(1));

        // Async reset mid-stall on r2
        iss_en_i   = 1'b1;
        iss_addr_i = 5'd2;
        rd_valid_i = 2'b00;
        tick();
        tick();
        iss_en_i   = 1'b0;
        rd_addr_i  = {5'd2, 5'd9};
        rd_valid_i = 2'b11;
        #1;
        chk("ar_stall_pre", 64'(stall_o), 64'(1));
        chk("ar_rd_pre", 64'(rd_data_o[31:0]), 64'h7);
        #2;
        rst_i = 1'b0;
        #1;
        chk("ar_stall", 64'(stall_o), 64'(0));
        chk("ar_iss_rdy", 64'(iss_rdy_o), 64'(1));
        chk("ar_err", 64'(err_o), 64'(0));
        chk("ar_rd", rd_data_o, 64'h0);
        tick();
        rst_i = 1'b1;
        tick();
        chk("ar_rd_post", rd_data_o, 64'h0);
        chk("ar_stall_post", 64'(stall_o), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
